// File: rtl/adder_4bit_seq_pkg.sv
// Shared definitions for the 4-bit adder sequencing stage.
//
// Holds the operand/result width shared with the sibling ripple-carry
// adder and the state encoding of the sequencing FSM.
package adder_4bit_seq_pkg;

    // Operand/result width of the sibling adder.
    localparam int WIDTH = 4;

    // Sequencing FSM: collect A, collect B, let the adder settle, hand off.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GOT_A = 2'd1,
        S_ADD   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage : adder_4bit_seq_pkg

// File: rtl/adder_4bit_seq.sv
// Sequencing stage wrapped around a 4-bit ripple-carry adder.
//
// Two operands arrive serially on one valid/ready bus (first beat A,
// second beat B). They are parked on in_1/in_2, which feed a sibling
// adder instance in the parent. After one settle cycle the adder's sum is
// captured and offered on a valid/ready result bus. op_cnt counts results
// handed off and wraps silently.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   din_valid  in   1      operand on din is valid
//   din_ready  out  1      operand can be accepted this cycle
//   din        in   WIDTH  operand data (A then B)
//   in_1       out  WIDTH  operand A to adder
//   in_2       out  WIDTH  operand B to adder
//   sum        in   WIDTH  adder result, combinational from in_1/in_2
//   res_valid  out  1      result available
//   res_ready  in   1      consumer accepts result
//   res        out  WIDTH  captured sum
//   op_cnt     out  CNT_W  number of results handed off
module adder_4bit_seq
    import adder_4bit_seq_pkg::*;
#(
    parameter int WIDTH = adder_4bit_seq_pkg::WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] in_1,
    output logic [WIDTH-1:0] in_2,
    input  logic [WIDTH-1:0] sum,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res,
    output logic [CNT_W-1:0] op_cnt
);

    state_t state;
    state_t state_next;

    logic din_fire;
    logic res_fire;

    assign din_fire = din_valid && din_ready;
    assign res_fire = res_valid && res_ready;

    // Next-state and handshake decode. din_ready/res_valid depend on the
    // registered state only, so din_ready never loops back through din_valid.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        din_ready  = 1'b0;
        res_valid  = 1'b0;
        unique case (state)
            S_IDLE: begin
                din_ready = 1'b1;
                if (din_valid) state_next = S_GOT_A;
            end
            S_GOT_A: begin
                din_ready = 1'b1;
                if (din_valid) state_next = S_ADD;
            end
            S_ADD: begin
                // One full cycle with stable in_1/in_2 lets the ripple carry settle.
                state_next = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, operand, result and counter registers.
    always_ff @(posedge clk) begin
        // NOTE: a handful of flops, so all of them are reset; this also makes
        // a mid-operation reset drop any partial operands and undelivered result.
        if (!rst_n) begin
            state  <= S_IDLE;
            in_1   <= '0;
            in_2   <= '0;
            res    <= '0;
            op_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state <= state_next;
            if (din_fire && (state == S_IDLE))  in_1 <= din;
            if (din_fire && (state == S_GOT_A)) in_2 <= din;
            if (state == S_ADD)                 res  <= sum;
            // Carry-out is not part of the result; op_cnt wraps freely.
            if (res_fire)                       op_cnt <= op_cnt + 1'b1;
        end
    end

endmodule : adder_4bit_seq

// File: tb/tb_adder_4bit_seq.sv
// Self-checking bench for adder_4bit_seq. The sibling adder is modelled
// as a plain continuous assignment; expected results come from integer
// arithmetic modulo 16 and a handoff counter modulo 256.
module tb_adder_4bit_seq;

    localparam int W     = 4;
    localparam int CW    = 8;
    localparam int TO    = 20;

    logic          clk;
    logic          rst_n;
    logic          din_valid;
    logic          din_ready;
    logic [W-1:0]  din;
    logic [W-1:0]  in_1;
    logic [W-1:0]  in_2;
    logic [W-1:0]  sum;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res;
    logic [CW-1:0] op_cnt;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        int           ready_delay;
        bit           hold_ready;
        bit           pulse_din;
    } vec_t;

    vec_t vecs[7];

    adder_4bit_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din       (din),
        .in_1      (in_1),
        .in_2      (in_2),
        .sum       (sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res       (res),
        .op_cnt    (op_cnt)
    );

    // Sibling adder in the parent.
    assign sum = in_1 + in_2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge and sample 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        s = (int'(a) + int'(b)) % 16;
        return s[W-1:0];
    endfunction

    // Present one beat and wait (bounded) for it to be taken.
    task automatic send_beat(input logic [W-1:0] d);
        int n;
        n = 0;
        din_valid = 1'b1;
        din       = d;
        while (!din_ready && n < TO) begin
            tick();
            n++;
        end
        if (n >= TO) check("din_ready_timeout", 32'd0, 32'd1);
        tick();
        din_valid = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input int gap,
                          input int ready_delay, input bit hold_ready,
                          input bit pulse_din);
        res_ready = hold_ready;
        din_valid = 1'b0;
        repeat (gap) tick();
        send_beat(a);
        check("a_loaded", 32'(in_1), 32'(a));
        check("got_a_ready", 32'(din_ready), 32'd1);
        send_beat(b);
        // ADD cycle
        check("b_loaded", 32'(in_2), 32'(b));
        check("add_valid", 32'(res_valid), 32'd0);
        check("add_ready", 32'(din_ready), 32'd0);
        check("add_cnt", 32'(op_cnt), 32'(exp_cnt));
        if (pulse_din) begin
            din_valid = 1'b1;
            din       = ~a;
        end
        tick();
        // First DONE cycle
        check("done_valid", 32'(res_valid), 32'd1);
        check("done_res", 32'(res), 32'(exp_res));
        check("done_ready", 32'(din_ready), 32'd0);
        for (int i = 0; i < ready_delay; i++) begin
            res_ready = 1'b0;
            if (pulse_din) begin
                din_valid = i[0];
                din       = ~b;
            end
            tick();
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_res", 32'(res), 32'(exp_res));
            check("bp_din_ready", 32'(din_ready), 32'd0);
            check("bp_in_1", 32'(in_1), 32'(a));
            check("bp_in_2", 32'(in_2), 32'(b));
            check("bp_cnt", 32'(op_cnt), 32'(exp_cnt));
        end
        din_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        exp_cnt = (exp_cnt + 1) % 256;
        check("handoff_valid", 32'(res_valid), 32'd0);
        check("handoff_ready", 32'(din_ready), 32'd1);
        check("handoff_cnt", 32'(op_cnt), 32'(exp_cnt));
        res_ready = hold_ready;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int start_cnt;

        rst_n     = 1'b0;
        din_valid = 1'b1;
        din       = 4'hF;
        res_ready = 1'b0;

        // Reset with a live operand on the bus.
        repeat (2) tick();
        check("rst_in_1", 32'(in_1), 32'd0);
        check("rst_in_2", 32'(in_2), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);
        rst_n     = 1'b1;
        din_valid = 1'b0;
        tick();
        check("rst_din_ready", 32'(din_ready), 32'd1);
        check("rst_in_1_held", 32'(in_1), 32'd0);

        // Directed vectors: {a, b, expected res, ready delay, hold ready, din pulses}
        vecs[0] = '{4'h3, 4'h5, 4'h8, 0, 1'b1, 1'b0};
        vecs[1] = '{4'h9, 4'h8, 4'h1, 0, 1'b0, 1'b0};
        vecs[2] = '{4'hF, 4'hF, 4'hE, 0, 1'b0, 1'b0};
        vecs[3] = '{4'h2, 4'h6, 4'h8, 5, 1'b0, 1'b1};
        vecs[4] = '{4'h0, 4'h0, 4'h0, 1, 1'b0, 1'b0};
        vecs[5] = '{4'h7, 4'h9, 4'h0, 0, 1'b1, 1'b1};
        vecs[6] = '{4'h1, 4'hE, 4'hF, 2, 1'b0, 1'b0};
        for (int v = 0; v < 7; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].exp_res, v % 2,
                   vecs[v].ready_delay, vecs[v].hold_ready, vecs[v].pulse_din);
        end

        // Idle with din_valid low: stays ready, nothing loads.
        res_ready = 1'b0;
        din       = 4'hA;
        repeat (3) tick();
        check("idle_hold_ready", 32'(din_ready), 32'd1);
        check("idle_hold_in_1", 32'(in_1), 32'h1);

        // Reset while holding A in GOT_A.
        send_beat(4'h7);
        check("midrst_a", 32'(in_1), 32'h7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        check("midrst_in_1", 32'(in_1), 32'd0);
        check("midrst_cnt", 32'(op_cnt), 32'd0);
        check("midrst_ready", 32'(din_ready), 32'd1);
        check("midrst_valid", 32'(res_valid), 32'd0);
        run_op(4'h1, 4'h1, 4'h2, 0, 0, 1'b0, 1'b0);
        check("midrst_res", 32'(res), 32'h2);

        // Random operations against the model; 256 handoffs wrap op_cnt.
        start_cnt = exp_cnt;
        for (int k = 0; k < 256; k++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_op(ra, rb, model_sum(ra, rb), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), 1'b0, 1'($urandom_range(0, 1)));
        end
        check("wrap_cnt", 32'(op_cnt), 32'(start_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_adder_4bit_seq
